// File: rtl/minesweeper_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : minesweeper_game_ctrl
//  Description : Game sequencer for the minesweeper core. Accepts reveal /
//                flag / new-game commands over a valid/ready handshake,
//                kicks the mine generator on the first reveal, counts the
//                mined neighbours of each revealed tile, writes the count
//                to the board store and tracks win/lose.
//  Options     : MINESWEEPER_FLAG_EN - enables the flag register; when
//                undefined, flag commands are accepted and ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module minesweeper_game_ctrl #(
  parameter int GRID_SIZE   = 8,
  parameter int TOTAL_TILES = GRID_SIZE * GRID_SIZE,
  parameter int INDEX_BITS  = $clog2(TOTAL_TILES),
  parameter int NUM_MINES   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [INDEX_BITS-1:0]  cmd_index,
  output logic                   gen_clear,
  output logic                   gen_start,
  output logic [INDEX_BITS-1:0]  gen_root,
  input  logic                   gen_done,
  input  logic [TOTAL_TILES-1:0] mine_map,
  output logic [TOTAL_TILES-1:0] revealed,
  output logic [TOTAL_TILES-1:0] flagged,
  output logic                   cnt_we,
  output logic [INDEX_BITS-1:0]  cnt_index,
  output logic [3:0]             cnt_value,
  output logic [1:0]             game_state
);

  localparam logic [1:0] OP_REVEAL = 2'b00;
  localparam logic [1:0] OP_FLAG   = 2'b01;
  localparam logic [1:0] OP_NEW    = 2'b10;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_PLAY = 2'b01;
  localparam logic [1:0] GS_LOST = 2'b10;
  localparam logic [1:0] GS_WON  = 2'b11;

  // Number of safe tiles; reaching it means every non-mine tile is open.
  localparam logic [INDEX_BITS:0] WIN_COUNT = (INDEX_BITS+1)'(TOTAL_TILES - NUM_MINES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_PLAY  = 3'd2,
    S_SCAN  = 3'd3,
    S_WRITE = 3'd4,
    S_LOST  = 3'd5,
    S_WON   = 3'd6
  } state_t;

  state_t                   state_q, state_d;
  logic                     gen_clear_q, gen_clear_d;
  logic                     gen_start_q, gen_start_d;
  logic [INDEX_BITS-1:0]    gen_root_q, gen_root_d;
  logic [INDEX_BITS-1:0]    target_q, target_d;
  logic [2:0]               step_q, step_d;
  logic [3:0]               acc_q, acc_d;
  logic                     cnt_we_q, cnt_we_d;
  logic [INDEX_BITS-1:0]    cnt_index_q, cnt_index_d;
  logic [3:0]               cnt_value_q, cnt_value_d;
  logic [TOTAL_TILES-1:0]   revealed_q, revealed_d;
  logic [INDEX_BITS:0]      nrev_q, nrev_d;
  logic [1:0]               game_state_q, game_state_d;

  logic                     fire;
  logic                     tile_flagged;
  int                       dr, dc, nr, nc;
  logic [INDEX_BITS-1:0]    nidx;
  logic                     nb_hit;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_PLAY) ||
                     (state_q == S_LOST) || (state_q == S_WON);
  assign fire      = cmd_valid & cmd_ready;

`ifdef MINESWEEPER_FLAG_EN
  logic [TOTAL_TILES-1:0]   flagged_q, flagged_d;
  assign tile_flagged = flagged_q[cmd_index];
  assign flagged      = flagged_q;

  // Flag mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flagged_q <= '0;
    else     flagged_q <= flagged_d;
  end
`else
  assign tile_flagged = 1'b0;
  assign flagged      = '0;
`endif

  // Neighbour selected by the scan step; off-grid neighbours never count.
  always_comb begin
    dr = 0;
    dc = 0;
    case (step_q)
      3'd0:    begin dr = -1; dc = -1; end
      3'd1:    begin dr = -1; dc =  0; end
      3'd2:    begin dr = -1; dc =  1; end
      3'd3:    begin dr =  0; dc = -1; end
      3'd4:    begin dr =  0; dc =  1; end
      3'd5:    begin dr =  1; dc = -1; end
      3'd6:    begin dr =  1; dc =  0; end
      default: begin dr =  1; dc =  1; end
    endcase
    nr     = (int'(target_q) / GRID_SIZE) + dr;
    nc     = (int'(target_q) % GRID_SIZE) + dc;
    nidx   = INDEX_BITS'(nr * GRID_SIZE + nc);
    nb_hit = 1'b0;
    if (nr >= 0 && nr < GRID_SIZE && nc >= 0 && nc < GRID_SIZE)
      nb_hit = mine_map[nidx];
  end

  // Next-state and registered-output logic of the game sequencer.
  always_comb begin
    state_d     = state_q;
    gen_clear_d = 1'b0;
    gen_start_d = 1'b0;
    gen_root_d  = gen_root_q;
    target_d    = target_q;
    step_d      = step_q;
    acc_d       = acc_q;
    cnt_we_d    = 1'b0;
    cnt_index_d = cnt_index_q;
    cnt_value_d = cnt_value_q;
    revealed_d  = revealed_q;
    nrev_d      = nrev_q;
`ifdef MINESWEEPER_FLAG_EN
    flagged_d   = flagged_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (fire && cmd_op == OP_REVEAL) begin
          gen_root_d  = cmd_index;
          gen_start_d = 1'b1;
          state_d     = S_GEN;
        end else if (fire && cmd_op == OP_NEW) begin
          gen_clear_d = 1'b1;
        end
      end
      S_GEN: begin
        if (gen_done) begin
          target_d = gen_root_q;
          step_d   = 3'd0;
          acc_d    = 4'd0;
          state_d  = S_SCAN;
        end
      end
      S_PLAY, S_LOST, S_WON: begin
        if (fire && cmd_op == OP_NEW) begin
          revealed_d  = '0;
          nrev_d      = '0;
          gen_clear_d = 1'b1;
          state_d     = S_IDLE;
`ifdef MINESWEEPER_FLAG_EN
          flagged_d   = '0;
`endif
        end else if (fire && state_q == S_PLAY && cmd_op == OP_REVEAL) begin
          if (!revealed_q[cmd_index] && !tile_flagged) begin
            if (mine_map[cmd_index]) begin
              revealed_d[cmd_index] = 1'b1;
              state_d               = S_LOST;
            end else begin
              target_d = cmd_index;
              step_d   = 3'd0;
              acc_d    = 4'd0;
              state_d  = S_SCAN;
            end
          end
        end else if (fire && state_q == S_PLAY && cmd_op == OP_FLAG) begin
`ifdef MINESWEEPER_FLAG_EN
          if (!revealed_q[cmd_index])
            flagged_d[cmd_index] = ~flagged_q[cmd_index];
`endif
        end
      end
      S_SCAN: begin
        acc_d  = acc_q + {3'b000, nb_hit};
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          cnt_we_d             = 1'b1;
          cnt_index_d          = target_q;
          cnt_value_d          = acc_q + {3'b000, nb_hit};
          revealed_d[target_q] = 1'b1;
          nrev_d               = nrev_q + {{INDEX_BITS{1'b0}}, 1'b1};
          state_d              = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = (nrev_q == WIN_COUNT) ? S_WON : S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_IDLE:  game_state_d = GS_IDLE;
      S_LOST:  game_state_d = GS_LOST;
      S_WON:   game_state_d = GS_WON;
      default: game_state_d = GS_PLAY;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gen_clear_q  <= 1'b0;
      gen_start_q  <= 1'b0;
      gen_root_q   <= '0;
      target_q     <= '0;
      step_q       <= 3'd0;
      acc_q        <= 4'd0;
      cnt_we_q     <= 1'b0;
      cnt_index_q  <= '0;
      cnt_value_q  <= 4'd0;
      revealed_q   <= '0;
      nrev_q       <= '0;
      game_state_q <= GS_IDLE;
    end else begin
      state_q      <= state_d;
      gen_clear_q  <= gen_clear_d;
      gen_start_q  <= gen_start_d;
      gen_root_q   <= gen_root_d;
      target_q     <= target_d;
      step_q       <= step_d;
      acc_q        <= acc_d;
      cnt_we_q     <= cnt_we_d;
      cnt_index_q  <= cnt_index_d;
      cnt_value_q  <= cnt_value_d;
      revealed_q   <= revealed_d;
      nrev_q       <= nrev_d;
      game_state_q <= game_state_d;
    end
  end

  assign gen_clear  = gen_clear_q;
  assign gen_start  = gen_start_q;
  assign gen_root   = gen_root_q;
  assign cnt_we     = cnt_we_q;
  assign cnt_index  = cnt_index_q;
  assign cnt_value  = cnt_value_q;
  assign revealed   = revealed_q;
  assign game_state = game_state_q;

endmodule
`default_nettype wire
